lockable_rr_arbiter: RTL and testbench
======================================

# lockable_rr_arbiter

Parametrised successor to the 4-input lockable priority encoder. Arbitrates N request lines into a registered grant index and valid flag, and selects fixed-priority or round-robin arbitration at runtime. A grant lock holds the current winner for multi-cycle transfers. A lock-hold limit forces release of a lock held too long, so no requester starves. Sits in front of shared-resource muxes; downstream logic consumes `grant_id`/`valid` directly.

## Interface
- `N`, default 8: number of request lines; N >= 2.
- `MAX_HOLD`, default 15: maximum consecutive cycles a grant may be held by lock; 0 disables the limit.
- Derived localparam `W = $clog2(N)`: width of `grant_id`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  N  request lines; bit i = requester i.
- `rr_mode`  in  1  arbitration mode: 0 = fixed priority (highest index wins), 1 = round-robin.
- `lock`  in  1  while high, freeze the current grant (subject to `MAX_HOLD`).
- `grant_id`  out  W  registered index of the granted requester.
- `valid`  out  1  registered; grant is live, i.e. the granted requester is requesting.
- `lock_expired`  out  1  registered one-cycle pulse; a lock was force-released by `MAX_HOLD`.

## Operation
- Internal state: `is_locked`, `locked_id` [W], `hold_cnt` [$clog2(MAX_HOLD+1)], `last` [W] (most recent arbitration winner).
- Combinational terms:
  - `expire = is_locked && MAX_HOLD != 0 && hold_cnt == MAX_HOLD`.
  - `use_lock = lock && !expire && (is_locked || valid)`.
  - `src = is_locked ? locked_id : grant_id`.
- Held path (`use_lock`):
  - `grant_id <= src`; `valid <= req[src]`.
  - If `!is_locked`: `is_locked <= 1`, `locked_id <= grant_id`, `hold_cnt <= 1`.
  - Else: `hold_cnt <= hold_cnt + 1`.
  - `last` is unchanged.
- Arbitration path (otherwise):
  - Fixed mode: the winner is the highest set index of `req`.
  - Round-robin mode: search order is last-1, last-2, … with wrap from 0 to N-1; `last` itself is checked last.
  - Winner found: `grant_id <= winner`, `valid <= 1`, `last <= winner` in either mode.
  - No request: `grant_id <= 0`, `valid <= 0`, `last` unchanged.
- Lock release:
  - `!lock`: `is_locked <= 0`, `hold_cnt <= 0`.
  - `expire` (lock high): `is_locked <= 0`, `hold_cnt <= 0`, `lock_expired <= 1`. Arbitration runs that edge.
  - If `lock` stays high, the next edge re-locks onto the new winner.
- `lock_expired <= 0` on every edge without `expire`.
- `lock` asserted while `valid=0` and unlocked: no lock is taken; arbitration runs.
- Locked requester drops its request: `grant_id` is held, `valid` = 0, and `hold_cnt` keeps counting, so expiry still releases it.
- `rr_mode` may change on any cycle. It takes effect at the next arbitration edge, using the current `last`.

## Timing
- Reset: `grant_id=0`, `valid=0`, `lock_expired=0`, `is_locked=0`, `locked_id=0`, `hold_cnt=0`, `last=0`. Reset overrides all other activity, including mid-lock.
- With `last=0`, the first round-robin search order is N-1…0, identical to fixed priority.
- Latency: `req` → `grant_id`/`valid` is 1 cycle.
- Lock: `lock` sampled high with `valid=1` freezes `grant_id` from the same edge. There is no extra cycle of arbitration.
- Lock hold: held for `MAX_HOLD` edges. On edge `MAX_HOLD+1`, arbitration runs and `lock_expired` pulses high for exactly one cycle.
- `lock` deasserted: arbitration resumes at that same edge.

## Test plan
- Reset, N=4: assert `rst` mid-lock with `req=4'b1111` → next cycle `grant_id=0`, `valid=0`, `lock_expired=0`. First round-robin grant after release is 3.
- Fixed priority, N=4, `rr_mode=0`:
  - `req=4'b0110` → `grant_id=2`, `valid=1` after 1 cycle.
  - Then `req=0` → `grant_id=0`, `valid=0`.
- Round-robin, N=4, `rr_mode=1`, `req=4'b1111` held → grants 3,2,1,0,3,2 on consecutive cycles.
  - Then `req=4'b0101` after grant 2 → 0,2,0.
- Lock hold, `req=4'b1000`:
  - grant 3, then `lock=1` and `req=4'b0001` → `grant_id=3`, `valid=0` held.
  - Drop `lock` → next cycle `grant_id=0`, `valid=1`.
- Expiry, N=4, `MAX_HOLD=3`, `rr_mode=1`, `req=4'b1111`, `lock=1` from the first grant:
  - `grant_id` = 3 for 4 cycles, then 2 with `lock_expired=1` for one cycle.
  - Then 2 holds for 4 cycles, then 1.
- `MAX_HOLD=0`: lock held for 100 cycles → `grant_id` constant, `lock_expired` never asserts.

Source files
------------

// File: rtl/lockable_rr_arbiter.sv
// N-way arbiter with runtime fixed-priority / round-robin selection and a
// grant lock that is force-released after MAX_HOLD consecutive held edges.
module lockable_rr_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 15,
  localparam int W       = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         rr_mode,
  input  logic         lock,
  output logic [W-1:0] grant_id,
  output logic         valid,
  output logic         lock_expired
);

  // With the limit disabled the counter is never compared, one bit is enough.
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

  logic [W-1:0]  grant_id_q, grant_id_d;
  logic          valid_q, valid_d;
  logic          lock_expired_q, lock_expired_d;
  logic          is_locked_q, is_locked_d;
  logic [W-1:0]  locked_id_q, locked_id_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [W-1:0]  last_q, last_d;

  logic          hit;
  logic [W-1:0]  fix_id, rr_id, win_id, src;
  logic          expire, use_lock;

  // Later loop iterations overwrite earlier ones, so the last match written
  // is the highest-priority one: highest index for fixed, last-1 first for RR.
  always_comb begin
    hit    = |req;
    fix_id = '0;
    rr_id  = '0;
    for (int i = 0; i < N; i++)
      if (req[i]) fix_id = W'(i);
    for (int k = N; k >= 1; k--)
      if (req[(int'(last_q) + N - k) % N]) rr_id = W'((int'(last_q) + N - k) % N);
    win_id = rr_mode ? rr_id : fix_id;
  end

  always_comb begin
    grant_id_d     = grant_id_q;
    valid_d        = valid_q;
    is_locked_d    = is_locked_q;
    locked_id_d    = locked_id_q;
    hold_cnt_d     = hold_cnt_q;
    last_d         = last_q;

    expire         = is_locked_q && (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM);
    use_lock       = lock && !expire && (is_locked_q || valid_q);
    src            = is_locked_q ? locked_id_q : grant_id_q;
    lock_expired_d = expire && lock;

    if (use_lock) begin
      grant_id_d = src;
      valid_d    = req[src];
      if (!is_locked_q) begin
        is_locked_d = 1'b1;
        locked_id_d = grant_id_q;
        hold_cnt_d  = HW'(1);
      end else begin
        hold_cnt_d  = hold_cnt_q + HW'(1);
      end
    end else begin
      // Every non-held edge leaves the arbiter unlocked.
      is_locked_d = 1'b0;
      hold_cnt_d  = '0;
      if (hit) begin
        grant_id_d = win_id;
        valid_d    = 1'b1;
        last_d     = win_id;
      end else begin
        grant_id_d = '0;
        valid_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id_q     <= '0;
      valid_q        <= 1'b0;
      lock_expired_q <= 1'b0;
      is_locked_q    <= 1'b0;
      locked_id_q    <= '0;
      hold_cnt_q     <= '0;
      last_q         <= '0;
    end else begin
      grant_id_q     <= grant_id_d;
      valid_q        <= valid_d;
      lock_expired_q <= lock_expired_d;
      is_locked_q    <= is_locked_d;
      locked_id_q    <= locked_id_d;
      hold_cnt_q     <= hold_cnt_d;
      last_q         <= last_d;
    end
  end

  assign grant_id     = grant_id_q;
  assign valid        = valid_q;
  assign lock_expired = lock_expired_q;

endmodule

// File: tb/tb_lockable_rr_arbiter.sv
// Two arbiters (N=4/MAX_HOLD=3 and N=8/MAX_HOLD=0) checked every cycle against a
// cycle-count based model, plus directed literal expectations.
module tb_lockable_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req8 = '0;
  logic       rr_mode = 1'b0;
  logic       lock = 1'b0;

  logic [1:0] ga;
  logic       va, ea;
  logic [2:0] gb;
  logic       vb, eb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lockable_rr_arbiter #(.N(4), .MAX_HOLD(3)) u_a (
    .clk(clk), .rst(rst), .req(req8[3:0]), .rr_mode(rr_mode), .lock(lock),
    .grant_id(ga), .valid(va), .lock_expired(ea));

  lockable_rr_arbiter #(.N(8), .MAX_HOLD(0)) u_b (
    .clk(clk), .rst(rst), .req(req8), .rr_mode(rr_mode), .lock(lock),
    .grant_id(gb), .valid(vb), .lock_expired(eb));

  // Model state per instance: lock is tracked by the edge number it was taken.
  int m_n[2]   = '{4, 8};
  int m_max[2] = '{3, 0};
  int m_grant[2], m_last[2], m_lid[2], m_since[2];
  bit m_valid[2], m_exp[2], m_locked[2];
  int edge_no = 0;
  bit armed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", name, act, want, $time);
    end
  endtask

  function automatic int pick(input int n, input logic [7:0] r, input bit rr, input int last);
    if (rr) begin
      for (int k = 1; k <= n; k++)
        if (r[(last - k + n) % n]) return (last - k + n) % n;
    end else begin
      for (int i = n - 1; i >= 0; i--)
        if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input int u, input logic [7:0] r);
    bit ex, held;
    int w;
    if (rst) begin
      m_grant[u] = 0; m_valid[u] = 0; m_exp[u] = 0;
      m_locked[u] = 0; m_lid[u] = 0; m_last[u] = 0; m_since[u] = 0;
      return;
    end
    ex   = m_locked[u] && m_max[u] != 0 && (edge_no - m_since[u]) == m_max[u];
    held = lock && !ex && (m_locked[u] || m_valid[u]);
    if (held) begin
      if (!m_locked[u]) begin
        m_locked[u] = 1; m_lid[u] = m_grant[u]; m_since[u] = edge_no;
      end
      m_grant[u] = m_lid[u];
      m_valid[u] = r[m_lid[u]];
    end else begin
      m_locked[u] = 0;
      w = pick(m_n[u], r, rr_mode, m_last[u]);
      if (w >= 0) begin
        m_grant[u] = w; m_valid[u] = 1; m_last[u] = w;
      end else begin
        m_grant[u] = 0; m_valid[u] = 0;
      end
    end
    m_exp[u] = ex && lock;
  endtask

  always @(posedge clk) begin
    edge_no++;
    model_step(0, req8 & 8'h0F);
    model_step(1, req8);
    if (rst) armed = 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("a_grant", 32'(ga), 32'(m_grant[0]));
      chk("a_valid", 32'(va), 32'(m_valid[0]));
      chk("a_exp",   32'(ea), 32'(m_exp[0]));
      chk("b_grant", 32'(gb), 32'(m_grant[1]));
      chk("b_valid", 32'(vb), 32'(m_valid[1]));
      chk("b_exp",   32'(eb), 32'(m_exp[1]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; lock = 1'b0; req8 = '0;
    step();
    rst = 1'b0;
  endtask

  int seq_rr[6]  = '{3, 2, 1, 0, 3, 2};
  int seq_rr2[3] = '{0, 2, 0};

  initial begin
    step(); step();
    chk("reset_grant", 32'(ga), 0);
    chk("reset_valid", 32'(va), 0);
    chk("reset_exp",   32'(ea), 0);
    rst = 1'b0;

    // fixed priority
    rr_mode = 1'b0; req8 = 8'b0110; step();
    chk("fix_grant", 32'(ga), 2);
    chk("fix_valid", 32'(va), 1);
    req8 = 8'b0000; step();
    chk("fix_idle_grant", 32'(ga), 0);
    chk("fix_idle_valid", 32'(va), 0);

    // round robin from last=0
    do_reset();
    rr_mode = 1'b1; req8 = 8'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_seq", 32'(ga), 32'(seq_rr[i]));
    end
    req8 = 8'b0101;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_seq2", 32'(ga), 32'(seq_rr2[i]));
    end

    // lock hold with dropped request
    do_reset();
    rr_mode = 1'b1; req8 = 8'b1000; step();
    chk("lk_first", 32'(ga), 3);
    lock = 1'b1; req8 = 8'b0001;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("lk_hold_grant", 32'(ga), 3);
      chk("lk_hold_valid", 32'(va), 0);
    end
    lock = 1'b0; step();
    chk("lk_rel_grant", 32'(ga), 0);
    chk("lk_rel_valid", 32'(va), 1);

    // expiry on the MAX_HOLD=3 instance
    do_reset();
    rr_mode = 1'b1; req8 = 8'b1111; lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("exp_g3", 32'(ga), 3);
      chk("exp_e0", 32'(ea), 0);
    end
    step();
    chk("exp_g2", 32'(ga), 2);
    chk("exp_pulse", 32'(ea), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("exp_g2_hold", 32'(ga), 2);
      chk("exp_e0b", 32'(ea), 0);
    end
    step();
    chk("exp_g1", 32'(ga), 1);
    chk("exp_pulse2", 32'(ea), 1);

    // reset while locked
    step();
    rst = 1'b1; step();
    chk("rst_lock_grant", 32'(ga), 0);
    chk("rst_lock_valid", 32'(va), 0);
    chk("rst_lock_exp",   32'(ea), 0);
    rst = 1'b0; lock = 1'b0; rr_mode = 1'b1; step();
    chk("rst_first_rr", 32'(ga), 3);

    // unlimited hold on the MAX_HOLD=0 instance
    do_reset();
    rr_mode = 1'b0; req8 = 8'h0F; lock = 1'b1; step();
    chk("nolim_first", 32'(gb), 3);
    for (int i = 0; i < 100; i++) begin
      step();
      chk("nolim_grant", 32'(gb), 3);
      chk("nolim_exp", 32'(eb), 0);
    end

    // random traffic, model-checked every cycle
    lock = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      req8    = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) req8 = '0;
      if ($urandom_range(0, 7) == 0) rr_mode = ~rr_mode;
      if ($urandom_range(0, 9) == 0) lock = ~lock;
      step();
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
